// File: rtl/pipeline_pkg.sv
// Shared types and defaults for the pipeline stall/flush controller.
package pipeline_pkg;

   typedef enum logic [1:0] {
      BOOT     = 2'd0,
      RUN      = 2'd1,
      MEM_WAIT = 2'd2
   } ctrl_state_e;

   localparam int DEF_BOOT_CYCLES = 4;
   localparam int DEF_MEM_TIMEOUT = 16;

   // Width of a counter that must hold values 0..n-1 (never zero bits).
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear taking priority over increment.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_clr,
   input  logic         i_inc,
   output logic [W-1:0] o_count
);

   logic [W-1:0] r_count;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)                    r_count <= '0;
      else if (i_clr)                 r_count <= '0;
      else if (i_inc && ~&r_count)    r_count <= r_count + 1'b1;
   end

   assign o_count = r_count;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 5-stage RV32I pipeline: boot hold, memory-wait
// freeze with timeout, redirect and load-use handling, plus perf counters.
module pipeline_ctrl
   import pipeline_pkg::*;
#(
   parameter int BOOT_CYCLES = DEF_BOOT_CYCLES,
   parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
   parameter int CNT_W       = 32
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_ctrl_load_use,
   input  logic             i_ctrl_redirect_execute,
   input  logic             i_ctrl_mem_req,
   input  logic             i_ctrl_mem_ready,
   input  logic             i_ctrl_cnt_clr,
   output logic             o_ctrl_pc_en,
   output logic             o_ctrl_pc_redirect,
   output logic             o_ctrl_ifid_en,
   output logic             o_ctrl_idex_en,
   output logic             o_ctrl_exmem_en,
   output logic             o_ctrl_memwb_en,
   output logic             o_ctrl_ifid_flush,
   output logic             o_ctrl_idex_flush,
   output logic             o_ctrl_memwb_flush,
   output logic             o_ctrl_mem_err,
   output logic [CNT_W-1:0] o_ctrl_stall_cnt,
   output logic [CNT_W-1:0] o_ctrl_flush_cnt,
   output logic [CNT_W-1:0] o_ctrl_wait_cnt
);

   localparam int BW = idx_width(BOOT_CYCLES);
   localparam int TW = idx_width(MEM_TIMEOUT);
   localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);
   localparam logic [TW-1:0] WAIT_LAST = TW'(MEM_TIMEOUT - 1);

   ctrl_state_e   r_state, w_next;
   logic [BW-1:0] r_boot_cnt;
   logic [TW-1:0] r_wait_ctr;

   logic w_mem_stall, w_timeout, w_freeze, w_run_rules, w_redir, w_lu;

   // mem_req dropping counts as completion, so only req & !ready stalls.
   assign w_mem_stall = i_ctrl_mem_req & ~i_ctrl_mem_ready;
   assign w_timeout   = (r_state == MEM_WAIT) & w_mem_stall & (r_wait_ctr == WAIT_LAST);
   assign w_freeze    = ((r_state == RUN) & w_mem_stall) |
                        ((r_state == MEM_WAIT) & w_mem_stall & ~w_timeout);
   assign w_run_rules = (r_state != BOOT) & ~w_freeze;
   assign w_redir     = w_run_rules & i_ctrl_redirect_execute;
   assign w_lu        = w_run_rules & ~i_ctrl_redirect_execute & i_ctrl_load_use;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) r_state <= BOOT;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         BOOT:     if (r_boot_cnt == BOOT_LAST) w_next = RUN;
         RUN:      if (w_mem_stall)             w_next = MEM_WAIT;
         MEM_WAIT: if (!w_freeze)               w_next = RUN;
         default:                               w_next = BOOT;
      endcase
   end

   always_comb begin
      o_ctrl_pc_en       = 1'b0;
      o_ctrl_pc_redirect = 1'b0;
      o_ctrl_ifid_en     = 1'b0;
      o_ctrl_idex_en     = 1'b0;
      o_ctrl_exmem_en    = 1'b0;
      o_ctrl_memwb_en    = 1'b0;
      o_ctrl_ifid_flush  = 1'b1;
      o_ctrl_idex_flush  = 1'b1;
      o_ctrl_memwb_flush = 1'b1;
      o_ctrl_mem_err     = 1'b0;
      if (r_state != BOOT) begin
         o_ctrl_ifid_flush  = 1'b0;
         o_ctrl_idex_flush  = 1'b0;
         if (w_freeze) begin
            o_ctrl_memwb_en    = 1'b1;
            o_ctrl_memwb_flush = 1'b1;
         end else begin
            o_ctrl_pc_en       = 1'b1;
            o_ctrl_ifid_en     = 1'b1;
            o_ctrl_idex_en     = 1'b1;
            o_ctrl_exmem_en    = 1'b1;
            o_ctrl_memwb_en    = 1'b1;
            o_ctrl_memwb_flush = w_timeout;
            o_ctrl_mem_err     = w_timeout;
            if (w_redir) begin
               o_ctrl_pc_redirect = 1'b1;
               o_ctrl_ifid_flush  = 1'b1;
               o_ctrl_idex_flush  = 1'b1;
            end else if (w_lu) begin
               o_ctrl_pc_en      = 1'b0;
               o_ctrl_ifid_en    = 1'b0;
               o_ctrl_idex_flush = 1'b1;
            end
         end
      end
   end

   // Wait counter is held at zero in RUN so it starts fresh on every MEM_WAIT entry.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_boot_cnt <= '0;
         r_wait_ctr <= '0;
      end else begin
         r_boot_cnt <= (r_state == BOOT) ? r_boot_cnt + 1'b1 : '0;
         r_wait_ctr <= (r_state == MEM_WAIT) ? r_wait_ctr + 1'b1 : '0;
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_clr   (i_ctrl_cnt_clr),
      .i_inc   (w_lu),
      .o_count (o_ctrl_stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_clr   (i_ctrl_cnt_clr),
      .i_inc   (w_redir),
      .o_count (o_ctrl_flush_cnt)
   );

   sat_counter #(.W(CNT_W)) u_wait_cnt (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_clr   (i_ctrl_cnt_clr),
      .i_inc   (w_freeze),
      .o_count (o_ctrl_wait_cnt)
   );

endmodule
